// File: rtl/clk_div_drv.sv
// clk_div_drv: NCH independent 50% duty programmable clock dividers with a common sync strobe.
// Optional macro CLKDIV_PHASE_EN adds per-channel phase_cfg and a WAIT delay before the first HIGH.
module clk_div_drv #(
  parameter int NCH = 4,
  parameter int CW  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*CW-1:0] half_cfg,
`ifdef CLKDIV_PHASE_EN
  input  logic [NCH*CW-1:0] phase_cfg,
`endif
  input  logic [NCH-1:0]    en,
  input  logic              sync,
  output logic [NCH-1:0]    outp,
  output logic [NCH-1:0]    outm,
  output logic [NCH-1:0]    active,
  inout  wire               VDD,
  inout  wire               VSS
);

  // state  | meaning
  // IDLE   | channel stopped, outp low
  // WAIT   | phase delay after sync, outp low (CLKDIV_PHASE_EN only)
  // HIGH   | high half-period, cnt counts up to hl
  // LOW    | low half-period, cnt counts up to hl
`ifdef CLKDIV_PHASE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HIGH = 2'd2, S_LOW = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd2, S_LOW = 2'd3} state_t;
`endif

  wire unused_supply = VDD ^ VSS;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hl_q, hl_d;
    logic [CW-1:0] half_i;
    logic          cnt_tc;
    logic          outp_q, outm_q, active_q;

    assign half_i = half_cfg[i*CW +: CW];
    assign cnt_tc = (cnt_q == hl_q);

`ifdef CLKDIV_PHASE_EN
    logic [CW-1:0] phase_i;
    logic          wait_tc;
    assign phase_i = phase_cfg[i*CW +: CW];
    // in WAIT, cnt is reused as a down-counter ending at zero
    assign wait_tc = (cnt_q == '0);
`endif

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        hl_q     <= '0;
        outp_q   <= 1'b0;
        outm_q   <= 1'b1;
        active_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        hl_q     <= hl_d;
        outp_q   <= (state_d == S_HIGH);
        outm_q   <= (state_d != S_HIGH);
        active_q <= (state_d != S_IDLE);
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hl_d    = hl_q;
      if (sync) begin
        cnt_d = '0;
        if (en[i]) begin
          hl_d    = half_i;
          state_d = S_HIGH;
`ifdef CLKDIV_PHASE_EN
          if (phase_i != '0) begin
            state_d = S_WAIT;
            cnt_d   = phase_i - CW'(1);
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (en[i]) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              hl_d    = half_i;
            end
          end
`ifdef CLKDIV_PHASE_EN
          S_WAIT: begin
            if (!en[i]) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else if (wait_tc) begin
              state_d = S_HIGH;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
`endif
          S_HIGH: begin
            if (!cnt_tc) begin
              cnt_d = cnt_q + CW'(1);
            end else begin
              cnt_d = '0;
              if (en[i]) state_d = S_LOW;
              else       state_d = S_IDLE;
            end
          end
          S_LOW: begin
            if (!cnt_tc) begin
              cnt_d = cnt_q + CW'(1);
            end else begin
              cnt_d = '0;
              // ratio updates only land here, so a running period is never reshaped
              if (en[i]) begin
                state_d = S_HIGH;
                hl_d    = half_i;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign outp[i]   = outp_q;
    assign outm[i]   = outm_q;
    assign active[i] = active_q;
  end

endmodule

// File: tb/tb_clk_div_drv.sv
// Self-checking bench for clk_div_drv: period-position model plus directed literal traces.
// Builds with or without CLKDIV_PHASE_EN.
`timescale 1ns/1ps
module tb_clk_div_drv;
  localparam int NCH = 4;
  localparam int CW  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NCH*CW-1:0] half_cfg;
  logic [NCH-1:0]    en;
  logic              sync;
  logic [NCH-1:0]    outp, outm, active;
`ifdef CLKDIV_PHASE_EN
  logic [NCH*CW-1:0] phase_cfg;
`endif
  wire VDD, VSS;
  assign VDD = 1'b1;
  assign VSS = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  clk_div_drv #(.NCH(NCH), .CW(CW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .half_cfg (half_cfg),
`ifdef CLKDIV_PHASE_EN
    .phase_cfg(phase_cfg),
`endif
    .en       (en),
    .sync     (sync),
    .outp     (outp),
    .outm     (outm),
    .active   (active),
    .VDD      (VDD),
    .VSS      (VSS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a running channel sits at position pos within a 2*(hl+1) cycle period.
  bit m_run  [NCH];
  int m_pos  [NCH];
  int m_hl   [NCH];
  int m_wait [NCH];
  bit m_valid = 1'b0;

  function automatic void model_step();
    int h, ph;
    for (int i = 0; i < NCH; i++) begin
      h  = int'(half_cfg[i*CW +: CW]);
      ph = 0;
`ifdef CLKDIV_PHASE_EN
      ph = int'(phase_cfg[i*CW +: CW]);
`endif
      if (RST) begin
        m_run[i] = 0; m_wait[i] = 0; m_pos[i] = 0; m_hl[i] = 0;
      end else if (sync) begin
        m_wait[i] = 0; m_run[i] = 0; m_pos[i] = 0;
        if (en[i]) begin
          m_hl[i] = h;
          if (ph != 0) m_wait[i] = ph;
          else m_run[i] = 1;
        end
      end else if (m_wait[i] > 0) begin
        if (!en[i]) m_wait[i] = 0;
        else if (m_wait[i] == 1) begin m_wait[i] = 0; m_run[i] = 1; m_pos[i] = 0; end
        else m_wait[i]--;
      end else if (!m_run[i]) begin
        if (en[i]) begin m_run[i] = 1; m_pos[i] = 0; m_hl[i] = h; end
      end else if (m_pos[i] == m_hl[i]) begin
        if (en[i]) m_pos[i]++;
        else m_run[i] = 0;
      end else if (m_pos[i] == 2*m_hl[i] + 1) begin
        if (en[i]) begin m_pos[i] = 0; m_hl[i] = h; end
        else m_run[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
  endfunction

  always @(posedge CLK) begin
    logic [NCH-1:0] ep, em, ea;
    model_step();
    if (RST) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      for (int i = 0; i < NCH; i++) begin
        ep[i] = m_run[i] && (m_pos[i] <= m_hl[i]);
        ea[i] = m_run[i] || (m_wait[i] > 0);
      end
      em = ~ep;
      check("model_outp", 32'(outp), 32'(ep));
      check("model_outm", 32'(outm), 32'(em));
      check("model_active", 32'(active), 32'(ea));
    end
  end

  task automatic set_half(input int ch, input int v);
    half_cfg[ch*CW +: CW] = v[CW-1:0];
  endtask

  task automatic drain(input string name);
    en = '0;
    for (int k = 0; k < 40 && active != '0; k++) @(negedge CLK);
    check(name, 32'(active), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tr, ta;
    logic        act_all;
    RST = 1'b1; en = '0; sync = 1'b0; half_cfg = '0;
`ifdef CLKDIV_PHASE_EN
    phase_cfg = '0;
`endif
    repeat (3) @(negedge CLK);
    check("rst_outp", 32'(outp), 32'd0);
    check("rst_outm", 32'(outm), 32'hF);
    check("rst_active", 32'(active), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // ratio 2 on ch0: 0 then 3 high / 3 low
    tr = '0;
    tr[0] = outp[0];
    set_half(0, 2); en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin @(negedge CLK); tr[k] = outp[0]; end
    check("ratio2_trace", 32'(tr[12:0]), 32'h038E);

    // divide-by-2 on ch1 alongside ch0
    tr = '0; act_all = 1'b1;
    set_half(1, 0); en[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK); tr[k] = outp[1]; act_all = act_all & active[1];
    end
    check("div2_trace", 32'(tr[5:0]), 32'h15);
    check("div2_active", 32'(act_all), 32'd1);
    drain("drain_div2");

    // ratio change 1 -> 3 during HIGH
    tr = '0;
    set_half(0, 1); en[0] = 1'b1;
    @(negedge CLK); tr[0] = outp[0]; set_half(0, 3);
    for (int k = 1; k < 12; k++) begin @(negedge CLK); tr[k] = outp[0]; end
    check("ratio_change_trace", 32'(tr[11:0]), 32'h0F3);
    drain("drain_change");

    // graceful stop: en dropped in 2nd HIGH cycle
    tr = '0; ta = '0;
    set_half(0, 3); en[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK); tr[k] = outp[0]; ta[k] = active[0];
      if (k == 1) en[0] = 1'b0;
    end
    check("stop_outp", 32'(tr[7:0]), 32'h0F);
    check("stop_active", 32'(ta[7:0]), 32'h0F);
    drain("drain_stop");

    // alignment then reset mid-HIGH
    set_half(0, 2); set_half(1, 5); en = 4'b0011;
    repeat (7) @(negedge CLK);
    sync = 1'b1;
    @(negedge CLK);
    check("align_outp", 32'(outp[1:0]), 32'h3);
    check("align_active", 32'(active[1:0]), 32'h3);
    sync = 1'b0; RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_outp", 32'(outp), 32'd0);
    check("rst_mid_outm", 32'(outm), 32'hF);
    check("rst_mid_active", 32'(active), 32'd0);
    RST = 1'b0;

`ifdef CLKDIV_PHASE_EN
    // phase offset: ch0 immediate, ch1 delayed two cycles
    set_half(0, 3); set_half(1, 3); en = 4'b0011;
    phase_cfg[0*CW +: CW] = CW'(0);
    phase_cfg[1*CW +: CW] = CW'(2);
    repeat (3) @(negedge CLK);
    sync = 1'b1;
    @(negedge CLK);
    check("phase_t1_outp", 32'(outp[1:0]), 32'h1);
    check("phase_t1_active1", 32'(active[1]), 32'd1);
    sync = 1'b0;
    @(negedge CLK);
    check("phase_t2_outp1", 32'(outp[1]), 32'd0);
    @(negedge CLK);
    check("phase_t3_outp1", 32'(outp[1]), 32'd1);
    drain("drain_phase");
`endif

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NCH; i++) if ($urandom_range(15) == 0) en[i] = ~en[i];
      if ($urandom_range(7) == 0) set_half(int'($urandom_range(NCH-1)), int'($urandom_range(6)));
      if ($urandom_range(63) == 0) set_half(int'($urandom_range(NCH-1)), int'($urandom_range(2**CW-1)));
      sync = ($urandom_range(31) == 0);
      RST  = ($urandom_range(255) == 0);
`ifdef CLKDIV_PHASE_EN
      if ($urandom_range(15) == 0)
        phase_cfg[$urandom_range(NCH-1)*CW +: CW] = CW'($urandom_range(4));
`endif
    end
    @(negedge CLK);
    sync = 1'b0; RST = 1'b0;
    repeat (4) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
